// File: rtl/subway_pkg.sv
// Shared cell, action and FSM state encodings for the subway runner planner.
// Also holds the lane-cell accessor used by the planner and target selector.
package subway_pkg;

    typedef enum logic [1:0] {ROAD = 2'd0, LOW = 2'd1, HIGH = 2'd2, TRAIN = 2'd3} cell_t;
    typedef enum logic [1:0] {FWD = 2'd0, RIGHT = 2'd1, LEFT = 2'd2, JUMP = 2'd3} action_t;
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

    // Columns are zero-extended to the 8-lane maximum before lookup.
    function automatic cell_t cell_at(input logic [15:0] col, input int lane);
        return cell_t'(col[2*lane +: 2]);
    endfunction

endpackage

// File: rtl/subway_target_sel.sv
// Combinational: nearest non-train lane of a column to the current lane, lower index wins ties.
// If every lane is a train cell, the current lane is returned.
module subway_target_sel
    import subway_pkg::*;
#(
    parameter int N_LANES = 4,
    localparam int LW = $clog2(N_LANES)
) (
    input  logic [2*N_LANES-1:0] i_col,
    input  logic [LW-1:0]        i_lane,
    output logic [LW-1:0]        o_target
);

    logic w_found;
    int   w_lo;
    int   w_hi;

    // Search outward from the current lane; the lower side is tried first at each distance.
    always_comb begin
        o_target = i_lane;
        w_found  = 1'b0;
        w_lo     = 0;
        w_hi     = 0;
        for (int d = 0; d < N_LANES; d++) begin
            w_lo = int'(i_lane) - d;
            w_hi = int'(i_lane) + d;
            if (!w_found && w_lo >= 0) begin
                if (cell_at(16'(i_col), w_lo) != TRAIN) begin
                    o_target = LW'(w_lo);
                    w_found  = 1'b1;
                end
            end
            if (!w_found && w_hi < N_LANES) begin
                if (cell_at(16'(i_col), w_hi) != TRAIN) begin
                    o_target = LW'(w_hi);
                    w_found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/subway_planner.sv
// Streams TRACK_LEN columns and emits TRACK_LEN-1 runner moves; action a_c appears TRAIN_PERIOD+1 cycles after column c.
// No backpressure: input is a valid-only stream, output a fixed-latency burst. err exists only with SUBWAY_PLANNER_ERR_EN.
module subway_planner
    import subway_pkg::*;
#(
    parameter int N_LANES      = 4,
    parameter int TRACK_LEN    = 64,
    parameter int TRAIN_PERIOD = 8,
    localparam int LW = $clog2(N_LANES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [LW-1:0]        init,
    input  logic [2*N_LANES-1:0] in,
    output logic                 out_valid,
    output logic [1:0]           out
`ifdef SUBWAY_PLANNER_ERR_EN
    ,
    output logic                 err
`endif
);

    localparam int CW = $clog2(TRACK_LEN + TRAIN_PERIOD);
    localparam int PW = (TRAIN_PERIOD > 1) ? $clog2(TRAIN_PERIOD) : 1;
    localparam logic [CW-1:0] C_TP     = CW'(TRAIN_PERIOD);
    localparam logic [CW-1:0] C_TL     = CW'(TRACK_LEN);
    localparam logic [CW-1:0] C_LAST   = CW'(TRACK_LEN + TRAIN_PERIOD - 2);
    localparam logic [PW-1:0] C_PH_MAX = PW'(TRAIN_PERIOD - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_col_cnt;
    logic [PW-1:0]         r_phase;
    logic                  r_done;
    logic [LW-1:0]         r_lane;
    // Together with the live input this forms the window of columns c+1 .. c+TRAIN_PERIOD.
    logic [2*N_LANES-1:0]  r_buf [TRAIN_PERIOD-1];
    logic                  r_out_valid;
    action_t               r_out;

    logic                  w_take;
    logic                  w_dec_en;
    logic                  w_last;
    logic                  w_train_c;
    logic [2*N_LANES-1:0]  w_col;
    logic [2*N_LANES-1:0]  w_next_col;
    logic [2*N_LANES-1:0]  w_train_col;
    logic [LW-1:0]         w_target;
    logic [LW-1:0]         w_lane_nxt;
    action_t               w_act;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = FILL;
            FILL:    if (r_col_cnt == C_TP) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = IDLE;
                     else if (!in_valid) w_state_nxt = DRAIN;
            DRAIN:   if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    subway_target_sel #(.N_LANES(N_LANES)) u_target_sel (
        .i_col    (w_train_col),
        .i_lane   (r_lane),
        .o_target (w_target)
    );

    // r_col_cnt is the frame cycle t, so the decision for column c runs at t = c + TRAIN_PERIOD.
    always_comb begin
        w_take      = in_valid && !r_done && (r_state != DRAIN) && (r_col_cnt < C_TL);
        w_col       = w_take ? in : '0;
        w_dec_en    = (r_state != IDLE) && (r_col_cnt >= C_TP) && (r_col_cnt <= C_LAST);
        w_last      = w_dec_en && (r_col_cnt == C_LAST);
        w_train_c   = (r_phase == '0) && (r_col_cnt != C_TP);
        w_next_col  = r_buf[TRAIN_PERIOD-2];
        w_train_col = (r_phase == '0) ? w_col : r_buf[r_phase - 1'b1];
        w_act       = FWD;
        w_lane_nxt  = r_lane;
        if (!w_train_c && (r_lane < w_target) &&
            cell_at(16'(w_next_col), int'(r_lane) + 1) == ROAD) begin
            w_act      = RIGHT;
            w_lane_nxt = r_lane + 1'b1;
        end else if (!w_train_c && (r_lane > w_target) &&
                     cell_at(16'(w_next_col), int'(r_lane) - 1) == ROAD) begin
            w_act      = LEFT;
            w_lane_nxt = r_lane - 1'b1;
        end else if (cell_at(16'(w_next_col), int'(r_lane)) == LOW) begin
            w_act = JUMP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_cnt   <= '0;
            r_phase     <= '0;
            r_done      <= 1'b0;
            r_lane      <= '0;
            r_out_valid <= 1'b0;
            r_out       <= FWD;
            for (int i = 0; i < TRAIN_PERIOD-1; i++) r_buf[i] <= '0;
        end else begin
            r_buf[0] <= w_col;
            for (int i = 1; i < TRAIN_PERIOD-1; i++) r_buf[i] <= r_buf[i-1];
            if (w_state_nxt == IDLE) begin
                r_col_cnt <= '0;
                r_phase   <= '0;
                r_done    <= 1'b0;
            end else begin
                r_col_cnt <= r_col_cnt + 1'b1;
                r_phase   <= (r_phase == C_PH_MAX) ? '0 : r_phase + 1'b1;
                if (r_state != IDLE && !in_valid) r_done <= 1'b1;
            end
            if (r_state == IDLE && in_valid) r_lane <= init;
            else if (w_dec_en)               r_lane <= w_lane_nxt;
            r_out_valid <= w_dec_en;
            r_out       <= w_dec_en ? w_act : FWD;
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;

`ifdef SUBWAY_PLANNER_ERR_EN
    logic r_err;
    logic w_err;

    always_comb begin
        w_err = ((r_state == FILL || r_state == RUN) && !r_done && !in_valid && (r_col_cnt < C_TL))
             || (r_state == DRAIN && in_valid)
             || (w_take && (&in));
    end

    always_ff @(posedge clk) begin
        if (rst) r_err <= 1'b0;
        else     r_err <= w_err;
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_subway_planner.sv
// Scoreboard bench for subway_planner: a reference planner predicts every action and its cycle.
module tb_subway_planner;

    localparam int N  = 4;
    localparam int TL = 64;
    localparam int TP = 8;
    localparam int LW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic [LW-1:0]  init;
    logic [2*N-1:0] in;
    logic           out_valid;
    logic [1:0]     out;
`ifdef SUBWAY_PLANNER_ERR_EN
    logic           err;
`endif

    always #5 clk = ~clk;

    subway_planner #(.N_LANES(N), .TRACK_LEN(TL), .TRAIN_PERIOD(TP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .init      (init),
        .in        (in),
        .out_valid (out_valid),
        .out       (out)
`ifdef SUBWAY_PLANNER_ERR_EN
        ,
        .err       (err)
`endif
    );

    typedef struct {
        int act;
        int cyc;
    } exp_t;

    exp_t           q[$];
    logic [2*N-1:0] cols [TL];
    int             cyc    = 0;
    int             n_chk  = 0;
    int             n_err  = 0;
    int             n_out  = 0;
    int             n_errp = 0;
    bit             mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int cellv(input int c, input int ncols, input int lane);
        logic [2*N-1:0] v;
        if (c >= ncols || c >= TL) return 0;
        v = cols[c];
        return int'(v[2*lane +: 2]);
    endfunction

    // Reference planner: target = closest non-train lane by absolute distance, scanned low to high.
    task automatic push_expected(input int t0, input int ncols, input int ini);
        int p, tgt, best, j, a;
        bit tr;
        p = ini;
        for (int c = 0; c <= TL-2; c++) begin
            j   = (c / TP + 1) * TP;
            tgt = p;
            if (j < TL) begin
                best = -1;
                for (int l = 0; l < N; l++)
                    if (cellv(j, ncols, l) != 3 && (best < 0 || iabs(l - p) < iabs(best - p))) best = l;
                if (best >= 0) tgt = best;
            end
            tr = (c > 0) && (c % TP == 0);
            a  = 0;
            if (!tr && p < tgt && cellv(c+1, ncols, p+1) == 0) begin
                a = 1;
                p = p + 1;
            end else if (!tr && p > tgt && cellv(c+1, ncols, p-1) == 0) begin
                a = 2;
                p = p - 1;
            end else if (cellv(c+1, ncols, p) == 1) begin
                a = 3;
            end
            q.push_back('{act: a, cyc: t0 + TP + 1 + c});
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (out_valid) begin
                chk("q_nonempty", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("action", int'(out), e.act);
                    chk("action_cycle", cyc, e.cyc);
                    n_out++;
                end
            end else begin
                chk("idle_out", int'(out), 0);
                if (q.size() > 0 && q[0].cyc <= cyc) begin
                    chk("valid_expected", int'(out_valid), 1);
                    void'(q.pop_front());
                end
            end
        end
    end

`ifdef SUBWAY_PLANNER_ERR_EN
    always @(negedge clk) if (err === 1'b1) n_errp++;
`endif

    task automatic clear_cols();
        for (int c = 0; c < TL; c++) cols[c] = '0;
    endtask

    task automatic gen_random();
        logic [2*N-1:0] v;
        int r;
        cols[0] = '0;
        for (int c = 1; c < TL; c++) begin
            v = '0;
            for (int l = 0; l < N; l++) begin
                if (c % TP == 0) begin
                    v[2*l +: 2] = 2'd3;
                end else begin
                    r = $urandom_range(0, 7);
                    v[2*l +: 2] = (r < 4) ? 2'd0 : (r < 6) ? 2'd1 : 2'd2;
                end
            end
            if (c % TP == 0) begin
                r = $urandom_range(0, N-1);
                v[2*r +: 2] = 2'd0;
                if ($urandom_range(0, 1) == 1) begin
                    r = $urandom_range(0, N-1);
                    v[2*r +: 2] = 2'd2;
                end
            end
            cols[c] = v;
        end
    endtask

    task automatic run_frame(input int ncols, input int rst_at, input int ini);
        int t0;
        int k;
        bit aborted;
        aborted = 1'b0;
        @(posedge clk); #1;
        t0    = cyc;
        n_out = 0;
        push_expected(t0, ncols, ini);
        for (int t = 0; t < ncols; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
            end
            if (t == rst_at) begin
                aborted = 1'b1;
                break;
            end
            in_valid = 1'b1;
            in       = cols[t];
            init     = (t == 0) ? LW'(ini) : LW'($urandom);
        end
        if (aborted) begin
            rst      = 1'b1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            q.delete();
            @(negedge clk);
            chk("rst_mid_valid", int'(out_valid), 0);
            chk("rst_mid_out", int'(out), 0);
            repeat (3) @(posedge clk);
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in       = (2*N)'($urandom);
        k = 0;
        while (q.size() > 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        chk("drain_left", int'(q.size()), 0);
        chk("n_actions", n_out, TL-1);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout cycle %0d required finish", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        init     = '0;
        in       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out", int'(out), 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        clear_cols();
        run_frame(TL, -1, 2);

        // Train column 8 free only in lane 0, start in lane 3.
        clear_cols();
        cols[8] = 8'b11_11_11_00;
        run_frame(TL, -1, 3);

        // Low obstacle at column 5 in lane 1.
        clear_cols();
        cols[5] = 8'b00_00_01_00;
        run_frame(TL, -1, 1);

        // Target lane 3 blocked by high obstacles on columns 1..6.
        clear_cols();
        for (int c = 1; c <= 6; c++) cols[c] = 8'b10_00_00_00;
        cols[8] = 8'b00_11_11_11;
        run_frame(TL, -1, 2);

        for (int f = 0; f < 3; f++) begin
            gen_random();
            run_frame(TL, -1, $urandom_range(0, N-1));
        end

        gen_random();
        n_errp = 0;
        run_frame(40, -1, $urandom_range(0, N-1));
`ifdef SUBWAY_PLANNER_ERR_EN
        chk("err_pulses", n_errp, 1);
`endif

        gen_random();
        run_frame(TL, 20, 1);
        gen_random();
        run_frame(TL, -1, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
